// File: rtl/sprite_plotter_pkg.sv
// Shared duck_hunt definitions: plotter FSM states, screen geometry, colour width
// and the default 6x7 bird bitmap.
package duck_hunt_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} plotter_state_t;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int COLOUR_BITS = 3;

  // Rows listed bottom (row 6) to top (row 0); within a row the MSB is column 5.
  localparam logic [41:0] BIRD_SPRITE = {
    6'b100001,
    6'b010010,
    6'b011110,
    6'b111111,
    6'b110111,
    6'b011110,
    6'b001100
  };

  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_plotter_if.sv
// Request/pixel bus between a sprite requester (master) and sprite_plotter (slave).
interface sprite_plotter_if
  import duck_hunt_pkg::*;
#(
  parameter int SPR_W       = 6,
  parameter int SPR_H       = 7,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int COLOUR_BITS = duck_hunt_pkg::COLOUR_BITS
);
  logic                     start;
  logic [X_BITS-1:0]        x_org;
  logic [Y_BITS-1:0]        y_org;
  logic [SPR_W*SPR_H-1:0]   sprite_bits;
  logic [COLOUR_BITS-1:0]   colour_in;
  logic [COLOUR_BITS-1:0]   bg_colour;
  logic                     erase;
  logic                     flip_h;

  logic [X_BITS-1:0]        x_out;
  logic [Y_BITS-1:0]        y_out;
  logic [COLOUR_BITS-1:0]   colour_out;
  logic                     plot;
  logic                     busy;
  logic                     done;

  modport master (
    output start, x_org, y_org, sprite_bits, colour_in, bg_colour, erase, flip_h,
    input  x_out, y_out, colour_out, plot, busy, done
  );

  modport slave (
    input  start, x_org, y_org, sprite_bits, colour_in, bg_colour, erase, flip_h,
    output x_out, y_out, colour_out, plot, busy, done
  );
endinterface

// File: rtl/sprite_plotter_scan_counter.sv
// Row-major col/row walker over an SPR_W x SPR_H sprite; wraps to (0,0) after the
// last pixel and flags that pixel with o_last.
module sprite_scan_counter
  import duck_hunt_pkg::*;
#(
  parameter  int SPR_W = 6,
  parameter  int SPR_H = 7,
  localparam int CW    = cnt_bits(SPR_W),
  localparam int RW    = cnt_bits(SPR_H)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [CW-1:0] o_col,
  output logic [RW-1:0] o_row,
  output logic          o_last
);
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_col_end;
  logic          w_row_end;

  assign w_col_end = (r_col == CW'(SPR_W - 1));
  assign w_row_end = (r_row == RW'(SPR_H - 1));

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_enable) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = w_col_end && w_row_end;

endmodule

// File: rtl/sprite_plotter.sv
// Sprite rasteriser: latches a sprite request and emits one registered pixel per clock.
// Build option SPRITE_PLOTTER_CLIP_EN suppresses plot for pixels outside the screen.
module sprite_plotter
  import duck_hunt_pkg::*;
#(
  parameter int SPR_W       = 6,
  parameter int SPR_H       = 7,
  parameter int SCREEN_W    = duck_hunt_pkg::SCREEN_W,
  parameter int SCREEN_H    = duck_hunt_pkg::SCREEN_H,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int COLOUR_BITS = duck_hunt_pkg::COLOUR_BITS
) (
  input logic             clock,
  input logic             reset,
  sprite_plotter_if.slave bus
);
  localparam int N    = SPR_W * SPR_H;
  localparam int XS   = X_BITS + 1;
  localparam int YS   = Y_BITS + 1;
  localparam int CW   = cnt_bits(SPR_W);
  localparam int RW   = cnt_bits(SPR_H);
  localparam int IDXB = cnt_bits(N);

`ifdef SPRITE_PLOTTER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  plotter_state_t         r_state;
  logic [X_BITS-1:0]      r_x_org;
  logic [Y_BITS-1:0]      r_y_org;
  logic [N-1:0]           r_bits;
  logic [COLOUR_BITS-1:0] r_colour;
  logic                   r_flip;
  logic                   r_scan_end;

  logic [X_BITS-1:0]      r_x_out;
  logic [Y_BITS-1:0]      r_y_out;
  logic [COLOUR_BITS-1:0] r_colour_out;
  logic                   r_plot;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_accept;
  logic                   w_clear;
  logic                   w_enable;
  logic [CW-1:0]          w_col;
  logic [RW-1:0]          w_row;
  logic                   w_last;
  logic [X_BITS-1:0]      w_x_base;
  logic [Y_BITS-1:0]      w_y_base;
  logic [N-1:0]           w_bits;
  logic [COLOUR_BITS-1:0] w_colour;
  logic                   w_flip;
  logic [CW-1:0]          w_col_sel;
  logic [IDXB-1:0]        w_idx;
  logic [XS-1:0]          w_x_sum;
  logic [YS-1:0]          w_y_sum;
  logic                   w_in_screen;
  logic                   w_pixel;

  // The counter sits at (0,0) whenever IDLE; clearing in DONE keeps it there.
  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_clear  = (r_state == DONE);
  assign w_enable = w_accept || ((r_state == SCAN) && !r_scan_end);

  sprite_scan_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_col    (w_col),
    .o_row    (w_row),
    .o_last   (w_last)
  );

  // Pixel (0,0) is emitted on the accept edge, so it is indexed from the live request.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_x_base = r_x_org;
    w_y_base = r_y_org;
    w_bits   = r_bits;
    w_colour = r_colour;
    w_flip   = r_flip;
    if (r_state == IDLE) begin
      w_x_base = bus.x_org;
      w_y_base = bus.y_org;
      w_bits   = bus.sprite_bits;
      w_colour = bus.erase ? bus.bg_colour : bus.colour_in;
      w_flip   = bus.flip_h;
    end
  end

  assign w_col_sel   = w_flip ? (CW'(SPR_W - 1) - w_col) : w_col;
  assign w_idx       = IDXB'(w_row) * IDXB'(SPR_W) + IDXB'(w_col_sel);
  assign w_x_sum     = {1'b0, w_x_base} + XS'(w_col);
  assign w_y_sum     = {1'b0, w_y_base} + YS'(w_row);
  assign w_in_screen = (w_x_sum < XS'(SCREEN_W)) && (w_y_sum < YS'(SCREEN_H));
  assign w_pixel     = w_bits[w_idx] && (w_in_screen || !CLIP_EN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the latched request is reset too, so a stray output never shows X after reset.
      r_state      <= IDLE;
      r_x_org      <= '0;
      r_y_org      <= '0;
      r_bits       <= '0;
      r_colour     <= '0;
      r_flip       <= 1'b0;
      r_scan_end   <= 1'b0;
      r_x_out      <= '0;
      r_y_out      <= '0;
      r_colour_out <= '0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_plot <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (w_accept) begin
            r_x_org      <= bus.x_org;
            r_y_org      <= bus.y_org;
            r_bits       <= bus.sprite_bits;
            r_colour     <= w_colour;
            r_flip       <= bus.flip_h;
            r_state      <= SCAN;
            r_busy       <= 1'b1;
            r_x_out      <= w_x_sum[X_BITS-1:0];
            r_y_out      <= w_y_sum[Y_BITS-1:0];
            r_plot       <= w_pixel;
            r_colour_out <= w_colour;
            r_scan_end   <= w_last;
          end
        end
        SCAN: begin
          if (r_scan_end) begin
            r_state    <= DONE;
            r_plot     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_scan_end <= 1'b0;
          end else begin
            r_x_out      <= w_x_sum[X_BITS-1:0];
            r_y_out      <= w_y_sum[Y_BITS-1:0];
            r_plot       <= w_pixel;
            r_colour_out <= w_colour;
            r_scan_end   <= w_last;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.x_out      = r_x_out;
  assign bus.y_out      = r_y_out;
  assign bus.colour_out = r_colour_out;
  assign bus.plot       = r_plot;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: a 2x2 and a 6x7 instance checked cycle by
// cycle against a row-major reference of the sprite rules.
module tb_sprite_plotter;
  import duck_hunt_pkg::*;

`ifdef SPRITE_PLOTTER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef struct {
    int x;
    int y;
    bit plot;
  } pix_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  sprite_plotter_if #(.SPR_W(2), .SPR_H(2)) bus_s ();
  sprite_plotter_if #(.SPR_W(6), .SPR_H(7)) bus_b ();

  sprite_plotter #(.SPR_W(2), .SPR_H(2)) dut_s (.clock(clock), .reset(reset), .bus(bus_s));
  sprite_plotter #(.SPR_W(6), .SPR_H(7)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pixel k of a w-wide sprite in row-major order, straight from the sprite rules.
  function automatic pix_t ref_pixel(input int w, input int k, input logic [63:0] bits,
                                     input int xo, input int yo, input bit flip);
    pix_t p;
    int r, c, cp, xs, ys;
    r  = k / w;
    c  = k % w;
    cp = flip ? (w - 1 - c) : c;
    xs = xo + c;
    ys = yo + r;
    p.plot = bits[r * w + cp] && (!CLIP || (xs < SCREEN_W && ys < SCREEN_H));
    p.x    = xs % 256;
    p.y    = ys % 128;
    return p;
  endfunction

  task automatic scan_b(input string nm, input int xo, input int yo, input logic [41:0] bits,
                        input logic [2:0] col, input logic [2:0] bg, input bit er, input bit fl,
                        input bit repulse, output int plots);
    pix_t p;
    int exp_plots = 0, busys = 0, dones = 0;
    logic [2:0] ecol = er ? bg : col;
    plots = 0;
    @(negedge clock);
    bus_b.x_org = 8'(xo); bus_b.y_org = 7'(yo); bus_b.sprite_bits = bits;
    bus_b.colour_in = col; bus_b.bg_colour = bg; bus_b.erase = er; bus_b.flip_h = fl;
    bus_b.start = 1'b1;
    @(negedge clock);
    bus_b.start = 1'b0;
    bus_b.x_org = 8'($urandom); bus_b.y_org = 7'($urandom);
    bus_b.sprite_bits = 42'({$urandom, $urandom}); bus_b.colour_in = 3'($urandom);
    bus_b.bg_colour = 3'($urandom); bus_b.erase = 1'($urandom); bus_b.flip_h = 1'($urandom);
    for (int k = 1; k <= 43; k++) begin
      bus_b.start = 1'b0;
      if (k <= 42) begin
        p = ref_pixel(6, k - 1, 64'(bits), xo, yo, fl);
        exp_plots += int'(p.plot);
        check($sformatf("%s x c%0d", nm, k), 64'(bus_b.x_out), 64'(p.x));
        check($sformatf("%s y c%0d", nm, k), 64'(bus_b.y_out), 64'(p.y));
        check($sformatf("%s plot c%0d", nm, k), 64'(bus_b.plot), 64'(p.plot));
        if (p.plot) check($sformatf("%s col c%0d", nm, k), 64'(bus_b.colour_out), 64'(ecol));
      end else begin
        check($sformatf("%s done c%0d", nm, k), 64'(bus_b.done), 64'd1);
        check($sformatf("%s plot_end c%0d", nm, k), 64'(bus_b.plot), 64'd0);
      end
      plots += int'(bus_b.plot === 1'b1);
      busys += int'(bus_b.busy === 1'b1);
      dones += int'(bus_b.done === 1'b1);
      if (repulse && (k == 3 || k == 10 || k == 43)) bus_b.start = 1'b1;
      @(negedge clock);
    end
    bus_b.start = 1'b0;
    check({nm, " idle busy"}, 64'(bus_b.busy), 64'd0);
    check({nm, " idle done"}, 64'(bus_b.done), 64'd0);
    check({nm, " plot count"}, 64'(plots), 64'(exp_plots));
    check({nm, " busy count"}, 64'(busys), 64'd42);
    check({nm, " done count"}, 64'(dones), 64'd1);
  endtask

  task automatic scan_s(input string nm, input int xo, input int yo, input logic [3:0] bits,
                        input logic [2:0] col, input logic [2:0] bg, input bit er, input bit fl);
    pix_t p;
    logic [2:0] ecol = er ? bg : col;
    @(negedge clock);
    bus_s.x_org = 8'(xo); bus_s.y_org = 7'(yo); bus_s.sprite_bits = bits;
    bus_s.colour_in = col; bus_s.bg_colour = bg; bus_s.erase = er; bus_s.flip_h = fl;
    bus_s.start = 1'b1;
    @(negedge clock);
    bus_s.start = 1'b0;
    bus_s.sprite_bits = ~bits; bus_s.flip_h = ~fl; bus_s.x_org = 8'($urandom);
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) begin
        p = ref_pixel(2, k - 1, 64'(bits), xo, yo, fl);
        check($sformatf("%s x c%0d", nm, k), 64'(bus_s.x_out), 64'(p.x));
        check($sformatf("%s y c%0d", nm, k), 64'(bus_s.y_out), 64'(p.y));
        check($sformatf("%s plot c%0d", nm, k), 64'(bus_s.plot), 64'(p.plot));
        check($sformatf("%s busy c%0d", nm, k), 64'(bus_s.busy), 64'd1);
        check($sformatf("%s done c%0d", nm, k), 64'(bus_s.done), 64'd0);
        if (p.plot) check($sformatf("%s col c%0d", nm, k), 64'(bus_s.colour_out), 64'(ecol));
      end else begin
        check($sformatf("%s busy c%0d", nm, k), 64'(bus_s.busy), 64'd0);
        check($sformatf("%s done c%0d", nm, k), 64'(bus_s.done), 64'd1);
        check($sformatf("%s plot c%0d", nm, k), 64'(bus_s.plot), 64'd0);
      end
      @(negedge clock);
    end
    check({nm, " idle done"}, 64'(bus_s.done), 64'd0);
  endtask

  initial begin
    int plots;
    bus_s.start = 1'b0; bus_s.x_org = '0; bus_s.y_org = '0; bus_s.sprite_bits = '0;
    bus_s.colour_in = '0; bus_s.bg_colour = '0; bus_s.erase = 1'b0; bus_s.flip_h = 1'b0;
    bus_b.start = 1'b0; bus_b.x_org = '0; bus_b.y_org = '0; bus_b.sprite_bits = '0;
    bus_b.colour_in = '0; bus_b.bg_colour = '0; bus_b.erase = 1'b0; bus_b.flip_h = 1'b0;

    #1;
    check("rst x", 64'(bus_b.x_out), 64'd0);
    check("rst y", 64'(bus_b.y_out), 64'd0);
    check("rst colour", 64'(bus_b.colour_out), 64'd0);
    check("rst plot", 64'(bus_b.plot), 64'd0);
    check("rst busy", 64'(bus_b.busy), 64'd0);
    check("rst done", 64'(bus_b.done), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    scan_s("s_basic", 10, 20, 4'b1001, 3'b100, 3'b000, 1'b0, 1'b0);
    scan_s("s_flip", 10, 20, 4'b1001, 3'b100, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      scan_s($sformatf("s_rand%0d", i), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
             4'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));

    scan_b("b_erase", 50, 60, BIRD_SPRITE, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0, plots);
    check("b_erase popcount", 64'(plots), 64'($countones(BIRD_SPRITE)));
    scan_b("b_repulse", 30, 40, BIRD_SPRITE, 3'b010, 3'b001, 1'b0, 1'b1, 1'b1, plots);
    scan_b("b_edge", 157, 117, '1, 3'b101, 3'b000, 1'b0, 1'b0, 1'b0, plots);
    check("b_edge plots", 64'(plots), CLIP ? 64'd9 : 64'd42);
    scan_b("b_wrap", 253, 125, '1, 3'b011, 3'b000, 1'b0, 1'b1, 1'b0, plots);
    check("b_wrap plots", 64'(plots), CLIP ? 64'd0 : 64'd42);
    for (int i = 0; i < 3; i++)
      scan_b($sformatf("b_rand%0d", i), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
             42'({$urandom, $urandom}), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
             1'b0, plots);

    // Abort a 6x7 scan with an asynchronous reset in the middle of cycle 5.
    @(negedge clock);
    bus_b.x_org = 8'd20; bus_b.y_org = 7'd30; bus_b.sprite_bits = '1;
    bus_b.colour_in = 3'b110; bus_b.erase = 1'b0; bus_b.flip_h = 1'b0; bus_b.start = 1'b1;
    @(negedge clock);
    bus_b.start = 1'b0;
    repeat (4) @(negedge clock);
    check("abort pre busy", 64'(bus_b.busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("abort x", 64'(bus_b.x_out), 64'd0);
    check("abort y", 64'(bus_b.y_out), 64'd0);
    check("abort colour", 64'(bus_b.colour_out), 64'd0);
    check("abort plot", 64'(bus_b.plot), 64'd0);
    check("abort busy", 64'(bus_b.busy), 64'd0);
    check("abort done", 64'(bus_b.done), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("abort hold plot %0d", k), 64'(bus_b.plot), 64'd0);
      check($sformatf("abort hold done %0d", k), 64'(bus_b.done), 64'd0);
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("post abort done %0d", k), 64'(bus_b.done), 64'd0);
      check($sformatf("post abort busy %0d", k), 64'(bus_b.busy), 64'd0);
    end
    scan_b("b_after", 5, 6, BIRD_SPRITE, 3'b001, 3'b000, 1'b0, 1'b1, 1'b0, plots);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
